// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, ALU and response bundle for alu_share_arbiter
// slave  (arbiter side): takes reqN_*, drives reqN_ready, drives alu_op/a/b/shamt, takes alu_result/zero, drives rsp_*, takes rsp_ready
// master (environment side): the mirror image of slave
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid, req1_valid;
    logic [3:0]            req0_op, req1_op;
    logic [DATA_WIDTH-1:0] req0_a, req1_a, req0_b, req1_b;
    logic [4:0]            req0_shamt, req1_shamt;
    logic                  req0_ready, req1_ready;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_a, alu_b;
    logic [4:0]            alu_shamt;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  rsp_valid, rsp_id;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_zero;
    logic                  rsp_ready;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
        input  req0_shamt, req1_shamt,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b, alu_shamt,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
        output req0_shamt, req1_shamt,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b, alu_shamt,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two valid/ready requesters
// clk, reset (sync, active-low); bus: alu_share_arbiter_if.slave (requests, ALU drive/return, tagged response)
// grant_cnt0/grant_cnt1: saturating grant counters, present only when ALU_ARB_STATS_EN is defined
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input logic                 clk,
    input logic                 reset,
    alu_share_arbiter_if.slave  bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] grant_cnt0,
    output logic [CNT_WIDTH-1:0] grant_cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t                state;
    logic                  prio, id_q, rsp_valid_q, rsp_zero_q;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
    logic [4:0]            sh_q;
    logic                  grant, gnt_id;

    // prio picks the winner only under contention; a lone requester always wins
    always_comb begin
        grant  = reset && state == IDLE && (bus.req0_valid || bus.req1_valid);
        gnt_id = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    end

    assign bus.req0_ready = grant && !gnt_id;
    assign bus.req1_ready = grant && gnt_id;
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_shamt  = sh_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = rsp_zero_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            id_q        <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sh_q        <= '0;
            res_q       <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef ALU_ARB_STATS_EN
            grant_cnt0  <= '0;
            grant_cnt1  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (grant) begin
                    op_q  <= gnt_id ? bus.req1_op : bus.req0_op;
                    a_q   <= gnt_id ? bus.req1_a : bus.req0_a;
                    b_q   <= gnt_id ? bus.req1_b : bus.req0_b;
                    sh_q  <= gnt_id ? bus.req1_shamt : bus.req0_shamt;
                    id_q  <= gnt_id;
                    prio  <= !gnt_id;
                    state <= EXEC;
                end
                EXEC: begin
                    res_q       <= bus.alu_result;
                    rsp_zero_q  <= bus.alu_zero;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef ALU_ARB_STATS_EN
            if (grant && !gnt_id && grant_cnt0 != '1)
                grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
            if (grant && gnt_id && grant_cnt1 != '1)
                grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
`endif
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter against a transaction-level model
module tb_alu_share_arbiter;
`ifdef ALU_ARB_STATS_EN
    localparam int CW = 2;
    logic [CW-1:0] gc0, gc1;
    int m_c0, m_c1;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DATA_WIDTH(32)) bus ();

    alu_share_arbiter #(
        .DATA_WIDTH(32)
`ifdef ALU_ARB_STATS_EN
        , .CNT_WIDTH(CW)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(gc0),
        .grant_cnt1(gc1)
`endif
    );

    // ALU stub: 0 AND,1 OR,2 ADD,3 SUB,4 SLT,5 NOR,6 SLL,7 SRL,8 BEQ,9 BNE, others 0
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh);
        logic [31:0] r;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a + b;
            4'd3: r = a - b;
            4'd4: r = {31'b0, $signed(a) < $signed(b)};
            4'd5: r = ~(a | b);
            4'd6: r = a << sh;
            4'd7: r = a >> sh;
            4'd8: r = (a == b) ? 32'd0 : 32'd1;
            4'd9: r = (a != b) ? 32'd0 : 32'd1;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [31:0] alu_r;
    assign alu_r = alu_f(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_shamt);
    assign bus.alu_result = alu_r;
    assign bus.alu_zero = (alu_r == 32'd0);

    int n_tests = 0;
    int n_fail = 0;

    // model: ph 0 = free to accept, 1 = accepted last edge, 2 = response owed
    int ph = 0;
    logic prio_m = 1'b0;
    logic e_id;
    logic [3:0] e_op;
    logic [31:0] e_a, e_b, e_res;
    logic [4:0] e_sh;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic er0, er1;
        #1;
        er0 = reset && ph == 0 && bus.req0_valid && (!bus.req1_valid || prio_m == 1'b0);
        er1 = reset && ph == 0 && bus.req1_valid && (!bus.req0_valid || prio_m == 1'b1);
        chk("req0_ready", bus.req0_ready, er0);
        chk("req1_ready", bus.req1_ready, er1);
        chk("rsp_valid", bus.rsp_valid, ph == 2);
        if (ph == 2) begin
            chk("rsp_id", bus.rsp_id, e_id);
            chk("rsp_result", bus.rsp_result, e_res);
            chk("rsp_zero", bus.rsp_zero, e_res == 32'd0);
        end
        if (ph == 1) begin
            chk("alu_op", bus.alu_op, e_op);
            chk("alu_a", bus.alu_a, e_a);
            chk("alu_b", bus.alu_b, e_b);
            chk("alu_shamt", bus.alu_shamt, e_sh);
        end
`ifdef ALU_ARB_STATS_EN
        chk("grant_cnt0", gc0, m_c0);
        chk("grant_cnt1", gc1, m_c1);
`endif
        if (!reset) begin
            ph = 0;
            prio_m = 1'b0;
`ifdef ALU_ARB_STATS_EN
            m_c0 = 0;
            m_c1 = 0;
`endif
        end else if (er0 || er1) begin
            e_id  = er1;
            e_op  = er1 ? bus.req1_op : bus.req0_op;
            e_a   = er1 ? bus.req1_a : bus.req0_a;
            e_b   = er1 ? bus.req1_b : bus.req0_b;
            e_sh  = er1 ? bus.req1_shamt : bus.req0_shamt;
            e_res = alu_f(e_op, e_a, e_b, e_sh);
            prio_m = !er1;
            ph = 1;
`ifdef ALU_ARB_STATS_EN
            if (er0 && m_c0 < (1 << CW) - 1) m_c0++;
            if (er1 && m_c1 < (1 << CW) - 1) m_c1++;
`endif
        end else if (ph == 1) begin
            ph = 2;
        end else if (ph == 2 && bus.rsp_ready) begin
            ph = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_shamt = sh; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_shamt = sh; bus.req0_valid = 1'b1;
        end
    endtask

    // single uncontended transaction from IDLE with constant expectations
    task automatic txn(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] er, input logic ez);
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        set_req(id, op, a, b, sh);
        #1;
        chk("txn_ready", id ? bus.req1_ready : bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        chk("txn_valid", bus.rsp_valid, 1'b1);
        chk("txn_id", bus.rsp_id, id);
        chk("txn_result", bus.rsp_result, er);
        chk("txn_zero", bus.rsp_zero, ez);
        tick();
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_op = '0; bus.req1_op = '0; bus.req0_a = '0; bus.req1_a = '0;
        bus.req0_b = '0; bus.req1_b = '0; bus.req0_shamt = '0; bus.req1_shamt = '0;
        bus.rsp_ready = 1'b1;
`ifdef ALU_ARB_STATS_EN
        m_c0 = 0;
        m_c1 = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_op", bus.alu_op, 4'd0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        set_req(1'b0, 4'd2, 32'd5, 32'd7, 5'd0);
        tick();
        reset = 1'b1;

        txn(1'b0, 4'd2, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(1'b0, 4'd3, 32'd3, 32'd3, 5'd0);
        set_req(1'b1, 4'd6, 32'd1, 32'd0, 5'd4);
        #1;
        chk("cont_first_grant0", bus.req0_ready, 1'b1);
        tick();
        tick();
        chk("cont_rsp0_id", bus.rsp_id, 1'b0);
        chk("cont_rsp0_result", bus.rsp_result, 32'd0);
        chk("cont_rsp0_zero", bus.rsp_zero, 1'b1);
        tick();
        chk("cont_second_grant1", bus.req1_ready, 1'b1);
        tick();
        tick();
        chk("cont_rsp1_id", bus.rsp_id, 1'b1);
        chk("cont_rsp1_result", bus.rsp_result, 32'd16);
        tick();
        chk("cont_third_grant0", bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        tick();

        bus.rsp_ready = 1'b0;
        set_req(1'b0, 4'd0, 32'hff, 32'h0f, 5'd0);
        tick();
        bus.req0_valid = 1'b0;
        set_req(1'b1, 4'd1, 32'd1, 32'd2, 5'd0);
        tick();
        repeat (4) begin
            chk("bp_ready1", bus.req1_ready, 1'b0);
            chk("bp_result", bus.rsp_result, 32'h0f);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_grant_after", bus.req1_ready, 1'b1);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        tick();

        txn(1'b0, 4'd8, 32'h1234, 32'h1234, 5'd0, 32'd0, 1'b1);
        txn(1'b1, 4'd9, 32'd1, 32'd2, 5'd0, 32'd0, 1'b1);
        txn(1'b0, 4'd15, 32'hdead, 32'hbeef, 5'd3, 32'd0, 1'b1);

        set_req(1'b0, 4'd2, 32'd9, 32'd9, 5'd0);
        tick();
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_alu_a", bus.alu_a, 32'd0);
        txn(1'b1, 4'd2, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0);

        repeat (600) begin
            bus.req0_valid = ($urandom_range(0, 2) != 0);
            bus.req1_valid = ($urandom_range(0, 2) != 0);
            bus.req0_op = 4'($urandom_range(0, 15));
            bus.req1_op = 4'($urandom_range(0, 15));
            bus.req0_a = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
            bus.req0_b = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
            bus.req1_a = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
            bus.req1_b = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
            bus.req0_shamt = 5'($urandom);
            bus.req1_shamt = 5'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset = 1'b1;

`ifdef ALU_ARB_STATS_EN
        reset = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        reset = 1'b1;
        repeat (5) txn(1'b0, 4'd2, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0);
        chk("stats_cnt0_sat", gc0, 2'd3);
        chk("stats_cnt1", gc1, 2'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
